// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle processor control path: opcodes, FSM
// states and the mux/ALU select codes driven onto the datapath.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_OFFS = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT});
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle FSM (master) and the datapath/memory (slave).
interface multicycle_control_if #(parameter int CNT_W = 16);
  import cpu_pkg::*;

  // Handshake: C_MemRead/C_MemWrite hold a request until the cycle mem_ready=1
  // completes it; the watchdog is the only other way a request is withdrawn.
  logic [3:0]       opcode;
  logic             alu_zero;
  logic             mem_ready;
  logic             C_PCWrite;
  logic             C_PCWriteCond;
  logic [1:0]       C_PCSource;
  logic             C_IorD;
  logic             C_MemRead;
  logic             C_MemWrite;
  logic             C_IRWrite;
  logic             C_ALUSrcA;
  logic [1:0]       C_ALUSrcB;
  logic [1:0]       C_ALUOp;
  logic             C_RegWrite;
  logic             C_RegDstWrite;
  logic             C_MemToReg;
  logic             halted;
  logic             illegal_op;
  logic             mem_timeout;
  logic [CNT_W-1:0] instr_count;
  state_t           dbg_state;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output C_PCWrite, C_PCWriteCond, C_PCSource, C_IorD, C_MemRead, C_MemWrite,
           C_IRWrite, C_ALUSrcA, C_ALUSrcB, C_ALUOp, C_RegWrite, C_RegDstWrite,
           C_MemToReg, halted, illegal_op, mem_timeout, instr_count, dbg_state
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  C_PCWrite, C_PCWriteCond, C_PCSource, C_IorD, C_MemRead, C_MemWrite,
           C_IRWrite, C_ALUSrcA, C_ALUSrcB, C_ALUOp, C_RegWrite, C_RegDstWrite,
           C_MemToReg, halted, illegal_op, mem_timeout, instr_count, dbg_state
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request has waited; o_expired flags the
// LIMIT-th unserved cycle so the FSM can abandon the access on that edge.
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  assign o_expired = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multicycle CPU: sequences fetch through
// writeback, handshakes with memory, and counts retired instructions.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_opcode;
  logic [CNT_W-1:0] r_instr_count;
  logic             r_timeout;
  logic             w_retire;
  logic             w_set_timeout;
  logic             w_mem_state;
  logic             w_expired;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                       (r_state == S_MEM_WRITE);

  // Any state change counts as entry, so back-to-back memory states restart the count.
  mem_wait_timer #(.LIMIT(WAIT_LIMIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_next != r_state),
    .i_en     (w_mem_state && !bus.mem_ready),
    .o_expired(w_expired)
  );

  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) w_next = S_DECODE;
        else if (w_expired) begin w_next = S_HALT; w_set_timeout = 1'b1; end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:        w_next = S_R_EXEC;
          OP_ADDI:         w_next = S_I_EXEC;
          OP_LW, OP_SW:    w_next = S_MEM_ADDR;
          OP_BEQ:          w_next = S_BRANCH;
          OP_J:            w_next = S_JUMP;
          OP_HALT:   begin w_next = S_HALT; w_retire = 1'b1; end
          default:         w_next = S_FETCH;
        endcase
      end
      S_R_EXEC:   w_next = S_R_WB;
      S_I_EXEC:   w_next = S_I_WB;
      S_MEM_ADDR: w_next = (r_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (bus.mem_ready) w_next = S_MEM_WB;
        else if (w_expired) begin w_next = S_HALT; w_set_timeout = 1'b1; end
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready) begin w_next = S_FETCH; w_retire = 1'b1; end
        else if (w_expired) begin w_next = S_HALT; w_set_timeout = 1'b1; end
      end
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_FETCH;
      r_opcode      <= '0;
      r_instr_count <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= bus.opcode;
      if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
      if (w_set_timeout) r_timeout <= 1'b1;
    end
  end

  // Controls decode from the registered state; rst gates them so nothing is asserted in reset.
  always_comb begin
    bus.C_PCWrite     = 1'b0;
    bus.C_PCWriteCond = 1'b0;
    bus.C_PCSource    = PCSRC_ALU;
    bus.C_IorD        = 1'b0;
    bus.C_MemRead     = 1'b0;
    bus.C_MemWrite    = 1'b0;
    bus.C_IRWrite     = 1'b0;
    bus.C_ALUSrcA     = 1'b0;
    bus.C_ALUSrcB     = SRCB_REGB;
    bus.C_ALUOp       = ALUOP_ADD;
    bus.C_RegWrite    = 1'b0;
    bus.C_RegDstWrite = 1'b0;
    bus.C_MemToReg    = 1'b0;
    bus.halted        = 1'b0;
    bus.illegal_op    = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          bus.C_MemRead = 1'b1;
          bus.C_ALUSrcB = SRCB_ONE;
          bus.C_IRWrite = bus.mem_ready;
          bus.C_PCWrite = bus.mem_ready;
        end
        S_DECODE: begin
          bus.C_ALUSrcB  = SRCB_OFFS;
          bus.illegal_op = !is_legal_op(bus.opcode);
        end
        S_R_EXEC: begin
          bus.C_ALUSrcA = 1'b1;
          bus.C_ALUOp   = ALUOP_FUNCT;
        end
        S_I_EXEC, S_MEM_ADDR: begin
          bus.C_ALUSrcA = 1'b1;
          bus.C_ALUSrcB = SRCB_OFFS;
        end
        S_R_WB, S_I_WB: begin
          bus.C_RegWrite    = 1'b1;
          bus.C_RegDstWrite = 1'b1;
        end
        S_MEM_READ: begin
          bus.C_MemRead = 1'b1;
          bus.C_IorD    = 1'b1;
        end
        S_MEM_WB: begin
          bus.C_RegWrite = 1'b1;
          bus.C_MemToReg = 1'b1;
        end
        S_MEM_WRITE: begin
          bus.C_MemWrite = 1'b1;
          bus.C_IorD     = 1'b1;
        end
        S_BRANCH: begin
          bus.C_ALUSrcA     = 1'b1;
          bus.C_ALUOp       = ALUOP_SUB;
          bus.C_PCWriteCond = 1'b1;
          bus.C_PCSource    = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          bus.C_PCWrite  = 1'b1;
          bus.C_PCSource = PCSRC_JUMP;
        end
        S_HALT:  bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.mem_timeout = r_timeout;
  assign bus.instr_count = r_instr_count;
  assign bus.dbg_state   = r_state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the 16-bit multicycle processor. It sequences fetch, decode, execute, memory and writeback, and drives the register-file controls C_RegWrite, C_RegDstWrite and C_MemToReg. It also drives the PC, IR, ALU and memory controls, and handshakes with the unified memory via mem_ready. A watchdog bounds every memory wait, and a retired-instruction counter is provided for the bench and debug.

Parameters:
WAIT_LIMIT, 15, maximum cycles spent in any memory state without mem_ready before timing out.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
opcode  input  4  IR[15:12], sampled in DECODE
alu_zero  input  1  ALU zero flag, sampled in BRANCH
mem_ready  input  1  memory completes the current read/write this cycle
C_PCWrite  output  1  unconditional PC load
C_PCWriteCond  output  1  PC load if alu_zero
C_PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
C_IorD  output  1  0 PC address, 1 ALUOut address
C_MemRead  output  1  memory read request
C_MemWrite  output  1  memory write request
C_IRWrite  output  1  IR load
C_ALUSrcA  output  1  0 PC, 1 register A
C_ALUSrcB  output  2  00 regB, 01 const 1, 10 sign-extended offset
C_ALUOp  output  2  00 add, 01 sub, 10 funct decode
C_RegWrite  output  1  register file write enable
C_RegDstWrite  output  1  1 = write address from A_WriteRegRT_BT field, 0 = from A_RegSWLW field
C_MemToReg  output  1  1 = write data from MDR, 0 = from ALU
halted  output  1  FSM is in HALT
illegal_op  output  1  one-cycle pulse on an undefined opcode
mem_timeout  output  1  sticky until reset
instr_count  output  CNT_W  retired instructions, wraps

Behaviour:
- Reset (rst=0, asynchronous): state goes to FETCH; wait counter, instr_count and mem_timeout clear; every output is 0 while rst=0. After release, the first edge executes FETCH.
- Opcodes:
  - 0000 RTYPE, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 J, 1111 HALT.
  - All others are illegal: illegal_op pulses in DECODE, then FETCH, not counted as retired.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - IRWrite and PCWrite are asserted only in the cycle mem_ready=1 (combinationally qualified); the FSM then moves to DECODE.
  - Otherwise the FSM stays in FETCH and the wait counter increments.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - RTYPE to R_EXEC, ADDI to I_EXEC, LW/SW to MEM_ADDR, BEQ to BRANCH, J to JUMP, HALT to HALT.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then R_WB.
- R_WB: RegWrite=1, RegDstWrite=1, MemToReg=0, then FETCH; retire.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then I_WB.
- I_WB: identical controls to R_WB, then FETCH; retire.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state LW to MEM_READ, SW to MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1; on mem_ready go to MEM_WB, else hold.
- MEM_WB: RegWrite=1, RegDstWrite=0, MemToReg=1, then FETCH; retire.
- MEM_WRITE: MemWrite=1, IorD=1; on mem_ready go to FETCH and retire, else hold.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then FETCH; retire whether or not the branch is taken.
- JUMP: PCWrite=1, PCSource=10, then FETCH; retire.
- HALT: halted=1, all other controls 0; held until reset; HALT is counted as retired on entry.
- Watchdog:
  - The wait counter clears on entry to each memory state.
  - If it reaches WAIT_LIMIT with mem_ready still 0, the FSM sets mem_timeout and goes to HALT.
  - MemRead/MemWrite drop that same edge; no IR/PC/register write occurs.
- C_RegWrite is never asserted outside R_WB, I_WB and MEM_WB. MemRead and MemWrite are never both 1.
- instr_count increments by 1 per retire and wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants and state encoding (4-bit enum).
  - ALUOp, ALUSrcB and PCSource codes.
- One sub-module, mem_wait_timer: wait counter plus compare against WAIT_LIMIT, with clear/enable inputs and an expired output.

Test Plan:
- Reset mid-MEM_READ: drop rst -> all outputs 0 immediately; after release, state FETCH and instr_count=0.
- ADD with mem_ready tied 1:
  - Expect 4 cycles FETCH, DECODE, R_EXEC, R_WB.
  - R_WB drives RegWrite=1, RegDstWrite=1, MemToReg=0.
  - instr_count goes 0 -> 1.
- LW with mem_ready delayed 3 cycles in FETCH and 2 in MEM_READ:
  - IRWrite is high exactly 1 cycle.
  - MEM_WB drives RegWrite=1, RegDstWrite=0, MemToReg=1.
  - Total 5+3+2 = 10 cycles.
- BEQ with alu_zero=0 then alu_zero=1: PCWriteCond=1 and PCSource=01 in both cases; instr_count increments by 2.
- Opcode 1010 -> illegal_op pulse of 1 cycle, back to FETCH, instr_count unchanged.
- mem_ready held 0 in MEM_WRITE -> after 15 cycles mem_timeout=1 and halted=1, MemWrite=0; remains until rst=0.
